// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: counts enabled run cycles until the processor reaches HALT_PC
// (or an optional cycle limit expires), then streams every word of a banked
// memory out over a valid/ready interface, bank-major / address-minor.
module run_dump_ctrl #(
  parameter int          DATA_W  = 32,
  parameter int          PC_W    = 32,
  parameter int          BANKS   = 64,
  parameter int          DEPTH   = 512,
  parameter logic [31:0] HALT_PC = 32'h44,
  parameter int          TIMEOUT = 0,
  parameter int          CYC_W   = 32,
  localparam int         BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int         ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PC_W-1:0]   pc,
  output logic              mem_rd_en,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic [CYC_W-1:0]  cycles,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam logic [PC_W-1:0]   HALT_V = PC_W'(HALT_PC);
  localparam logic [CYC_W-1:0]  TO_V   = CYC_W'(TIMEOUT);
  localparam logic [BANK_W-1:0] LAST_B = BANK_W'(BANKS - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    RUN, ISSUE, CAPTURE, SEND, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc_inc;
  logic             cyc_en, start, to_hit, capture, advance, finish;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state decode and per-state control strobes / status outputs.
  always_comb begin
    state_nxt  = state;
    cyc_inc    = (&cycles) ? cycles : cycles + 1'b1;
    cyc_en     = 1'b0;
    start      = 1'b0;
    to_hit     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    mem_rd_en  = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      RUN: begin
        if (en) begin
          cyc_en = 1'b1;
          if (pc == HALT_V) begin
            start     = 1'b1;
            state_nxt = ISSUE;
          end else if ((TIMEOUT != 0) && (cyc_inc == TO_V)) begin
            start     = 1'b1;
            to_hit    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (dump_last) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Datapath: cycle counter, dump index, captured word and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles    <= '0;
      timed_out <= 1'b0;
      mem_bank  <= '0;
      mem_addr  <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else begin
      if (cyc_en) cycles <= cyc_inc;
      if (to_hit) timed_out <= 1'b1;
      if (start) begin
        mem_bank <= '0;
        mem_addr <= '0;
      end
      if (capture) begin
        dump_data <= mem_rd_data;
        dump_last <= (mem_bank == LAST_B) && (mem_addr == LAST_A);
      end
      if (advance) begin
        if (mem_addr == LAST_A) begin
          mem_addr <= '0;
          mem_bank <= mem_bank + 1'b1;
        end else begin
          mem_addr <= mem_addr + 1'b1;
        end
      end
      if (finish) dump_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// tb_run_dump_ctrl: directed bench for run_dump_ctrl with BANKS=2, DEPTH=4.
// Two instances share the stimulus: dut0 without a cycle limit, dut1 with
// TIMEOUT=20. Memory models return {bank,addr} (bank<<8 | addr) one cycle
// after the read strobe.
module tb_run_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, dump_ready;
  logic [31:0] pc;
  logic        sel;

  logic        rd_en0, valid0, last0, busy0, done0, to0, bank0;
  logic [1:0]  addr0;
  logic [31:0] rdata0, data0, cycles0;
  logic        rd_en1, valid1, last1, busy1, done1, to1, bank1;
  logic [1:0]  addr1;
  logic [31:0] rdata1, data1, cycles1;

  logic        s_rd_en, s_valid, s_last, s_busy, s_done, s_to, s_bank;
  logic [1:0]  s_addr;
  logic [31:0] s_data, s_cycles;

  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  int base;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] exp_cyc;
    logic        exp_busy;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  run_dump_ctrl #(.DATA_W(32), .PC_W(32), .BANKS(2), .DEPTH(4),
                  .HALT_PC(32'h44), .TIMEOUT(0), .CYC_W(32)) dut0 (
    .clk(clk), .rst(rst), .en(en), .pc(pc),
    .mem_rd_en(rd_en0), .mem_bank(bank0), .mem_addr(addr0), .mem_rd_data(rdata0),
    .dump_valid(valid0), .dump_data(data0), .dump_last(last0), .dump_ready(dump_ready),
    .cycles(cycles0), .busy(busy0), .done(done0), .timed_out(to0));

  run_dump_ctrl #(.DATA_W(32), .PC_W(32), .BANKS(2), .DEPTH(4),
                  .HALT_PC(32'h44), .TIMEOUT(20), .CYC_W(32)) dut1 (
    .clk(clk), .rst(rst), .en(en), .pc(pc),
    .mem_rd_en(rd_en1), .mem_bank(bank1), .mem_addr(addr1), .mem_rd_data(rdata1),
    .dump_valid(valid1), .dump_data(data1), .dump_last(last1), .dump_ready(dump_ready),
    .cycles(cycles1), .busy(busy1), .done(done1), .timed_out(to1));

  // Memory models: data valid only in the cycle after the strobe.
  always @(posedge clk) rdata0 <= rd_en0 ? ((32'(bank0) << 8) | 32'(addr0)) : 32'hDEAD_BEEF;
  always @(posedge clk) rdata1 <= rd_en1 ? ((32'(bank1) << 8) | 32'(addr1)) : 32'hDEAD_BEEF;

  assign s_rd_en  = sel ? rd_en1  : rd_en0;
  assign s_valid  = sel ? valid1  : valid0;
  assign s_last   = sel ? last1   : last0;
  assign s_busy   = sel ? busy1   : busy0;
  assign s_done   = sel ? done1   : done0;
  assign s_to     = sel ? to1     : to0;
  assign s_bank   = sel ? bank1   : bank0;
  assign s_addr   = sel ? addr1   : addr0;
  assign s_data   = sel ? data1   : data0;
  assign s_cycles = sel ? cycles1 : cycles0;

  always @(negedge clk) if (s_rd_en) rd_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return 32'(((w / 4) << 8) | (w % 4));
  endfunction

  task automatic check_reset();
    chk("rst_cycles", s_cycles, 0);
    chk("rst_busy",   s_busy,   0);
    chk("rst_done",   s_done,   0);
    chk("rst_valid",  s_valid,  0);
    chk("rst_last",   s_last,   0);
    chk("rst_data",   s_data,   0);
    chk("rst_rd_en",  s_rd_en,  0);
    chk("rst_bank",   s_bank,   0);
    chk("rst_addr",   s_addr,   0);
    chk("rst_to",     s_to,     0);
  endtask

  // Collect the dump; optionally stall on one word or reset on one word.
  task automatic collect(input int stall_word, input int stall_len, input int rst_word);
    int budget;
    int b;
    for (int w = 0; w < 8; w++) begin
      budget = 0;
      while (!s_valid && budget < 10) begin
        tick();
        budget++;
      end
      if (!s_valid) begin
        chk("word_wait", 0, 1);
        return;
      end
      chk("word_data", s_data, exp_word(w));
      chk("word_last", 32'(s_last), 32'(w == 7));
      if (w == rst_word) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();
        return;
      end
      if (w == stall_word) begin
        dump_ready = 1'b0;
        b = rd_pulses;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          chk("stall_valid", s_valid, 1);
          chk("stall_data",  s_data,  exp_word(w));
          chk("stall_last",  32'(s_last), 32'(w == 7));
        end
        chk("stall_no_rd", rd_pulses, b);
        dump_ready = 1'b1;
      end
      tick();
      chk("post_hs_valid", s_valid, 0);
    end
    chk("dump_done", s_done, 1);
    chk("dump_busy", s_busy, 0);
  endtask

  initial begin
    // en toggling with halt on the 10th enabled cycle; pc=0x44 with en=0 ignored
    tbl[0]  = '{1'b1, 32'h0,  32'd1,  1'b0};
    tbl[1]  = '{1'b0, 32'h0,  32'd1,  1'b0};
    tbl[2]  = '{1'b1, 32'h10, 32'd2,  1'b0};
    tbl[3]  = '{1'b0, 32'h44, 32'd2,  1'b0};
    tbl[4]  = '{1'b1, 32'h0,  32'd3,  1'b0};
    tbl[5]  = '{1'b0, 32'h0,  32'd3,  1'b0};
    tbl[6]  = '{1'b1, 32'h0,  32'd4,  1'b0};
    tbl[7]  = '{1'b1, 32'h0,  32'd5,  1'b0};
    tbl[8]  = '{1'b1, 32'h0,  32'd6,  1'b0};
    tbl[9]  = '{1'b1, 32'h0,  32'd7,  1'b0};
    tbl[10] = '{1'b1, 32'h0,  32'd8,  1'b0};
    tbl[11] = '{1'b1, 32'h0,  32'd9,  1'b0};
    tbl[12] = '{1'b1, 32'h44, 32'd10, 1'b1};

    rst = 1'b1; en = 1'b0; pc = 32'h0; dump_ready = 1'b1; sel = 1'b0;
    tick();
    tick();
    check_reset();
    rst = 1'b0;

    // Halt-terminated run, no cycle limit
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en;
      pc = tbl[i].pc;
      tick();
      chk("tbl_cycles", s_cycles, tbl[i].exp_cyc);
      chk("tbl_busy",   s_busy,   32'(tbl[i].exp_busy));
      chk("tbl_to",     s_to,     0);
    end
    chk("issue_rd_en", s_rd_en, 1);
    chk("issue_bank", s_bank, 0);
    chk("issue_addr", s_addr, 0);
    base = rd_pulses;
    en = 1'b1; pc = 32'h44;
    collect(-1, 0, -1);
    chk("halt_rd_count", rd_pulses - base, 8);
    chk("halt_cycles", s_cycles, 10);
    chk("halt_to", s_to, 0);

    // pc toggling after done must not restart anything
    for (int k = 0; k < 6; k++) begin
      en = 1'b1;
      pc = (k % 2 == 0) ? 32'h44 : 32'h0;
      tick();
      chk("after_valid",  s_valid,  0);
      chk("after_done",   s_done,   1);
      chk("after_rd_en",  s_rd_en,  0);
      chk("after_cycles", s_cycles, 10);
    end

    // Cycle limit expires, stall on word 3
    sel = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset();
    en = 1'b1; pc = 32'h0;
    for (int i = 0; i < 19; i++) tick();
    chk("to19_cycles", s_cycles, 19);
    chk("to19_busy", s_busy, 0);
    tick();
    chk("to20_cycles", s_cycles, 20);
    chk("to20_to", s_to, 1);
    chk("to20_busy", s_busy, 1);
    base = rd_pulses;
    en = 1'b0;
    collect(3, 5, -1);
    chk("to_rd_count", rd_pulses - base, 8);
    chk("to_cycles", s_cycles, 20);
    chk("to_flag", s_to, 1);

    // Halt on the limit cycle wins; reset mid-dump then re-dump from word 0
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; pc = 32'h0;
    for (int i = 0; i < 19; i++) tick();
    pc = 32'h44;
    tick();
    chk("tie_cycles", s_cycles, 20);
    chk("tie_to", s_to, 0);
    chk("tie_busy", s_busy, 1);
    collect(-1, 0, 5);
    en = 1'b1; pc = 32'h44;
    tick();
    chk("rerun_cycles", s_cycles, 1);
    chk("rerun_busy", s_busy, 1);
    chk("rerun_bank", s_bank, 0);
    chk("rerun_addr", s_addr, 0);
    en = 1'b0;
    collect(-1, 0, -1);
    chk("rerun_cycles_end", s_cycles, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_dump_ctrl.md
RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 32, dump word width.
REQ-002 SHALL have parameter PC_W, 32, program-counter width.
REQ-003 SHALL have parameter BANKS, 64, number of memory banks dumped; legal range >=1.
REQ-004 SHALL have parameter DEPTH, 512, words per bank; legal range >=2.
REQ-005 SHALL have parameter HALT_PC, 32'h44, PC value that ends the run.
REQ-006 SHALL have parameter TIMEOUT, 0, run-cycle limit; 0 disables it.
REQ-007 SHALL have parameter CYC_W, 32, cycle-counter width.
REQ-008 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock, rising edge.
REQ-009 SHALL have rst, in, 1: reset, synchronous, active-high.
REQ-010 SHALL have en, in, 1: processor enable; qualifies counting and halt detection.
REQ-011 SHALL have pc, in, PC_W: current processor PC.
REQ-012 SHALL have mem_rd_en, out, 1: read strobe to banked memory.
REQ-013 SHALL have mem_bank, out, clog2(BANKS) (min 1): bank select.
REQ-014 SHALL have mem_addr, out, clog2(DEPTH): word address within bank.
REQ-015 SHALL have mem_rd_data, in, DATA_W: read data, valid exactly 1 cycle after mem_rd_en.
REQ-016 SHALL have dump_valid, out, 1; dump_data, out, DATA_W; dump_last, out, 1; dump_ready, in, 1: dump stream.
REQ-017 SHALL have cycles, out, CYC_W: run cycle count.
REQ-018 SHALL have busy, out, 1; done, out, 1; timed_out, out, 1: status.

Function
REQ-019 SHALL implement FSM states RUN, ISSUE, CAPTURE, SEND, DONE; state RUN after reset.
REQ-020 SHALL, in RUN with en=1, increment cycles by 1 per clock, saturating at all-ones; en=0 holds cycles and ignores pc.
REQ-021 SHALL, in RUN with en=1 and pc==HALT_PC, count that cycle, then go to ISSUE with index 0.
REQ-022 SHALL, when TIMEOUT!=0 and the increment makes cycles==TIMEOUT in RUN, set timed_out=1 and go to ISSUE; halt match in the same cycle takes priority (timed_out stays 0).
REQ-023 SHALL freeze cycles in every state other than RUN.
REQ-024 SHALL, in ISSUE, assert mem_rd_en=1 for exactly one cycle with mem_bank/mem_addr of the current index, then go to CAPTURE.
REQ-025 SHALL, in CAPTURE, register mem_rd_data into dump_data, then go to SEND.
REQ-026 SHALL, in SEND, hold dump_valid=1 with dump_data stable until dump_ready=1; dump_data/dump_last SHALL NOT change while dump_valid=1 and dump_ready=0.
REQ-027 SHALL advance on handshake in index order bank-major, address-minor: addr 0..DEPTH-1 of bank 0, then bank 1, through BANKS*DEPTH words.
REQ-028 SHALL assert dump_last with the final word (bank BANKS-1, addr DEPTH-1); handshake of that word goes to DONE.
REQ-029 SHALL return to ISSUE after any non-last handshake (one word per >=3 cycles).
REQ-030 SHALL ignore en and pc in ISSUE, CAPTURE, SEND and DONE.
REQ-031 SHALL, in DONE, hold done=1, dump_valid=0, mem_rd_en=0, cycles and timed_out stable until rst.
REQ-032 SHALL drive busy=1 in ISSUE, CAPTURE, SEND; 0 in RUN and DONE.
REQ-033 SHALL drive mem_rd_en=0 in all states except ISSUE.

Reset
REQ-034 SHALL, with rst=1 at a clock edge, set state RUN, cycles=0, index 0, dump_valid=0, dump_last=0, dump_data=0, mem_rd_en=0, mem_bank=0, mem_addr=0, busy=0, done=0, timed_out=0.
REQ-035 SHALL honour rst in any state, including mid-dump; rst takes priority over all other inputs, and the next dump restarts at bank 0 addr 0.

Verification (BANKS=2, DEPTH=4, memory model returns {bank,addr} as data)
REQ-036 SHALL cover: en=1, pc reaches 32'h44 on 10th enabled cycle, dump_ready=1 -> cycles=10, eight words 0x0..0x3,0x100..0x103 emitted, dump_last only on 0x103, then done=1.
REQ-037 SHALL cover: en toggled 0/1 every cycle during run -> cycles equals number of en=1 cycles only.
REQ-038 SHALL cover: TIMEOUT=20, pc never 0x44 -> cycles=20, timed_out=1, full dump follows; TIMEOUT=20 with pc=0x44 on cycle 20 -> timed_out=0.
REQ-039 SHALL cover: dump_ready held low 5 cycles on word 3 -> dump_valid and dump_data stable all 5 cycles, no mem_rd_en pulse.
REQ-040 SHALL cover: rst pulsed while in SEND of word 5 -> all outputs at reset values next cycle, new run re-dumps from word 0.
REQ-041 SHALL cover: pc toggling 0x44 after done -> no further dump_valid, cycles unchanged.
